dct_odd_pipe: RTL

Parametrised, pipelined odd-part butterfly multiplier for the 2D DCT processor. It takes the K = POINTS/2 butterfly differences b[0..K-1] from the even/odd split and computes the odd-indexed transform outputs y[1], y[3], …, y[POINTS-1]. It supports the 8-point and 16-point odd matrices, a programmable output right-shift, and valid/ready flow control with bubble-collapsing stalls. It sits between the butterfly stage and the transpose buffer, in both the row and column passes.

---
 rtl/dct_odd_pkg.sv | 31 +++
 rtl/dct_odd_row.sv | 14 +
 rtl/dct_odd_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/dct_odd_pkg.sv
// dct_odd_pkg: odd-part DCT coefficient tables and per-row lookup helpers
package dct_odd_pkg;
  localparam int C8 [4][4] = '{
    '{89, 75, 50, 18},
    '{75, -18, -89, -50},
    '{50, -89, 18, 75},
    '{18, -50, 75, -89}
  };
  localparam int C16 [8][8] = '{
    '{90, 87, 80, 70, 57, 43, 25, 9},
    '{87, 57, 9, -43, -80, -90, -70, -25},
    '{80, 9, -70, -87, -25, 57, 90, 43},
    '{70, -43, -87, 9, 90, 25, -80, -57},
    '{57, -80, -25, 90, -9, -87, 43, 70},
    '{43, -90, 57, 25, -87, 70, 9, -80},
    '{25, -70, 90, -80, 43, 9, -57, 87},
    '{9, -25, 43, -57, 70, -80, 87, -90}
  };
  function automatic int coef(input int points, input int k, input int n);
    return points == 16 ? C16[k % 8][n % 8] : C8[k % 4][n % 4];
  endfunction
  function automatic int coef_mag(input int points, input int k, input int n);
    return coef(points, k, n) < 0 ? -coef(points, k, n) : coef(points, k, n);
  endfunction
  function automatic logic [7:0] neg_row(input int points, input int k);
    logic [7:0] m;
    m = '0;
    for (int n = 0; n < 8; n++) m[n] = coef(points, k, n) < 0;
    return m;
  endfunction
endpackage

// File: rtl/dct_odd_row.sv
// dct_odd_row: signed sum of one row of magnitude products; NEG selects subtraction per term
module dct_odd_row #(
  parameter int K = 4,
  parameter int ACC_W = 25,
  parameter logic [K-1:0] NEG = '0
) (
  input  logic [K*ACC_W-1:0] prod,
  output logic [ACC_W-1:0]   sum
);
  always_comb begin
    sum = '0;
    for (int n = 0; n < K; n++) sum = NEG[n] ? sum - prod[n*ACC_W +: ACC_W] : sum + prod[n*ACC_W +: ACC_W];
  end
endmodule

// File: rtl/dct_odd_pipe.sv
// dct_odd_pipe: 3-stage odd-part DCT butterfly multiplier with valid/ready flow control.
// Define DCT_ODD_ROUND_EN to round half-up on the output shift instead of flooring.
module dct_odd_pipe
  import dct_odd_pkg::*;
#(
  parameter int POINTS = 8,
  parameter int IN_W = 16,
  parameter int SHIFT = 0,
  localparam int K = POINTS / 2,
  localparam int ACC_W = IN_W + 9,
  localparam int OUT_W = ACC_W - SHIFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K*IN_W-1:0]  in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [K*OUT_W-1:0] out_y
);
  if (POINTS != 8 && POINTS != 16) begin : g_bad_points
    $error("dct_odd_pipe: POINTS must be 8 or 16");
  end
  if (SHIFT < 0 || SHIFT > 12) begin : g_bad_shift
    $error("dct_odd_pipe: SHIFT must be 0..12");
  end
  logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d, adv1, adv2, adv3;
  logic [K*K*ACC_W-1:0] prod_q, prod_d, prod_new;
  logic [K*ACC_W-1:0] sum_q, sum_d, sum_new;
  logic [K*OUT_W-1:0] y_q, y_d, y_new;
  always_comb begin
    adv3 = !v3_q || out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
    v1_d = adv1 ? in_valid : v1_q;
    v2_d = adv2 ? v1_q : v2_q;
    v3_d = adv3 ? v2_q : v3_q;
    prod_d = adv1 ? prod_new : prod_q;
    sum_d = adv2 ? sum_new : sum_q;
    y_d = adv3 ? y_new : y_q;
  end
  assign in_ready = adv1 && !rst;
  assign out_valid = v3_q;
  assign out_y = y_q;
  for (genvar k = 0; k < K; k++) begin : g_k
    // S1 keeps |C|*b; the row adder applies the coefficient sign
    for (genvar n = 0; n < K; n++) begin : g_n
      localparam int M = coef_mag(POINTS, k, n);
      logic signed [ACC_W-1:0] bx, p;
      assign bx = ACC_W'($signed(in_b[n*IN_W +: IN_W]));
      always_comb begin
        p = '0;
        for (int i = 0; i < 7; i++) p = M[i] ? p + (bx <<< i) : p;
      end
      assign prod_new[(k*K+n)*ACC_W +: ACC_W] = p;
    end
    localparam logic [7:0] NR = neg_row(POINTS, k);
    dct_odd_row #(.K(K), .ACC_W(ACC_W), .NEG(NR[K-1:0])) u_row (
      .prod(prod_q[k*K*ACC_W +: K*ACC_W]),
      .sum (sum_new[k*ACC_W +: ACC_W])
    );
    logic signed [ACC_W-1:0] s;
    assign s = sum_q[k*ACC_W +: ACC_W];
    if (SHIFT == 0) begin : g_pass
      assign y_new[k*OUT_W +: OUT_W] = s;
    end else begin : g_shift
`ifdef DCT_ODD_ROUND_EN
      logic signed [ACC_W:0] t;
      assign t = {s[ACC_W-1], s} + ((ACC_W+1)'(1) << (SHIFT - 1));
      assign y_new[k*OUT_W +: OUT_W] = OUT_W'(t >>> SHIFT);
`else
      assign y_new[k*OUT_W +: OUT_W] = OUT_W'(s >>> SHIFT);
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      prod_q <= '0;
      sum_q <= '0;
      y_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      prod_q <= prod_d;
      sum_q <= sum_d;
      y_q <= y_d;
    end
  end
endmodule
